// File: rtl/uart_tx_frame_ctrl.sv
// Purpose : UART TX frame sequencer; latches a word, computes parity, steps start/data/parity/stop fields into the TX mux.
// Latency : accept at edge E0 -> mux_sel=START for E0..E1, data bit k for E(1+k)..E(2+k), then parity (optional), then stop.
// Backpress: data_valid is only accepted while busy=0 (IDLE or STOP); requests while busy are dropped, not queued.
//
// Ports:
//   clk        bit-rate clock, rising edge
//   rst        asynchronous active-low reset
//   p_data     word to send, sampled on acceptance
//   data_valid send request
//   par_en     append parity bit (sampled on acceptance)
//   par_typ    0 = even, 1 = odd (sampled on acceptance)
//   mux_sel    field select to TX mux: 00 start, 01 data, 10 parity, 11 stop/idle
//   start_bit  constant 0
//   stop_bit   constant 1
//   ser_data   current data bit, LSB first
//   par_bit    parity of the latched word
//   busy       high in START, DATA, PARITY
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [1:0]            mux_sel,
  output logic                  start_bit,
  output logic                  stop_bit,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  accept;

  assign start_bit = 1'b0;
  assign stop_bit  = 1'b1;
  assign ser_data  = shift_reg[0];

  // busy and mux_sel depend on the state register only, so the mux select
  // never sees a combinational path from the request inputs.
  always_comb begin
    busy    = 1'b0;
    mux_sel = 2'b11;
    case (state_q)
      START:   begin mux_sel = 2'b00; busy = 1'b1; end
      DATA:    begin mux_sel = 2'b01; busy = 1'b1; end
      PARITY:  begin mux_sel = 2'b10; busy = 1'b1; end
      default: begin mux_sel = 2'b11; busy = 1'b0; end
    endcase
  end

  // STOP counts as not-busy so a held request starts the next frame straight
  // after a single stop bit.
  assign accept = data_valid & ~busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath. The word is not shifted on START->DATA: bit 0 must be on
  // ser_data for the whole first DATA cycle; each DATA edge then exposes
  // the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      par_bit   <= 1'b0;
      par_en_q  <= 1'b0;
      bit_cnt   <= '0;
    end else if (accept) begin
      shift_reg <= p_data;
      par_bit   <= (^p_data) ^ par_typ;
      par_en_q  <= par_en;
      bit_cnt   <= '0;
    end else if (state_q == DATA) begin
      shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      // Saturate on the last bit so the counter sits still until the next word.
      if (bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
